l2cache_control_nway: RTL and testbench

Parametrised N-way successor to the 2-way L2 cache controller FSM. It sequences hits, misses, dirty write-backs and line fills between the CPU-side request interface and physical memory. It drives per-way write, valid and dirty strobes and a pseudo-LRU update for a datapath holding WAYS ways. It also fixes the ordering of the older design: the dirty victim is written back before the fill read is issued, and invalid ways are filled before any valid line is evicted.

---
 rtl/l2cache_control_nway.sv | 194 +++++++++++++++++++
 tb/tb_l2cache_control_nway.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/l2cache_control_nway.sv
// l2cache_control_nway: N-way L2 cache controller FSM.
// Sequences hits, dirty write-backs, line fills and the PLRU update for a
// WAYS-way datapath. The dirty victim is written back before the fill read
// starts, and invalid ways are always filled before a valid line is evicted.
// Optional build macro L2_PERF_CNT_EN adds saturating hit/miss/write-back
// counters and a synchronous clear input (perf_clr).
//
// state       | meaning
// S_IDLE      | wait for a request; serve hits, classify misses
// S_WRITEBACK | write the dirty victim line back to physical memory
// S_FILL      | read the requested line from physical memory
// S_LOAD      | write the fetched line into the victim way, mark it valid
// S_RESP      | one-cycle response pulse to the CPU
module l2cache_control_nway #(
  parameter int WAYS = 4,
`ifdef L2_PERF_CNT_EN
  parameter int CNT_W = 32,
`endif
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  dirty,
  input  logic [WAY_W-1:0] plru_victim,
  input  logic             pmem_resp,
`ifdef L2_PERF_CNT_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count,
`endif
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             mem_addr_sel,
  output logic [WAY_W-1:0] way_sel,
  output logic             mem_b_sel,
  output logic [WAYS-1:0]  we,
  output logic [WAYS-1:0]  ld_valid,
  output logic [WAYS-1:0]  ld_dirty,
  output logic             dirty_in,
  output logic             lru_update,
  output logic [WAY_W-1:0] lru_way
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITEBACK = 3'd1,
    S_FILL      = 3'd2,
    S_LOAD      = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WAY_W-1:0] r_victim_q;

  logic             w_req;
  logic             w_any_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_any_invalid;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_victim;
  logic             w_victim_dirty;
  logic             w_idle_hit;
  logic             w_idle_miss;
  logic             w_wb_exit;

  assign w_req     = mem_read | mem_write;
  assign w_any_hit = |hit;

  // Priority encoders: lowest-index hit way and lowest-index invalid way.
  always_comb begin
    w_hit_way     = '0;
    w_inv_way     = '0;
    w_any_invalid = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit[i]) w_hit_way = WAY_W'(i);
      if (!valid[i]) begin
        w_inv_way     = WAY_W'(i);
        w_any_invalid = 1'b1;
      end
    end
  end

  assign w_victim       = w_any_invalid ? w_inv_way : plru_victim;
  assign w_victim_dirty = valid[w_victim] & dirty[w_victim];

  assign w_idle_hit  = (r_state == S_IDLE) & w_req & w_any_hit;
  assign w_idle_miss = (r_state == S_IDLE) & w_req & ~w_any_hit;
  assign w_wb_exit   = (r_state == S_WRITEBACK) & pmem_resp;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Victim way is latched when a miss is detected and held for the whole miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_victim_q <= '0;
    else if (w_idle_miss) r_victim_q <= w_victim;
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt  = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    mem_addr_sel = 1'b0;
    way_sel      = '0;
    mem_b_sel    = 1'b0;
    we           = '0;
    ld_valid     = '0;
    ld_dirty     = '0;
    dirty_in     = 1'b0;
    lru_update   = 1'b0;
    lru_way      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_any_hit) begin
            lru_update = 1'b1;
            lru_way    = w_hit_way;
            way_sel    = w_hit_way;
            if (mem_write) begin
              we[w_hit_way]       = 1'b1;
              ld_dirty[w_hit_way] = 1'b1;
              dirty_in            = 1'b1;
            end
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = w_victim_dirty ? S_WRITEBACK : S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        mem_addr_sel = 1'b1;
        way_sel      = r_victim_q;
        if (pmem_resp) begin
          ld_dirty[r_victim_q] = 1'b1;
          dirty_in             = 1'b0;
          w_state_nxt          = S_FILL;
        end
      end
      S_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        we[r_victim_q]       = 1'b1;
        mem_b_sel            = 1'b1;
        ld_valid[r_victim_q] = 1'b1;
        ld_dirty[r_victim_q] = 1'b1;
        dirty_in             = mem_write;
        lru_update           = 1'b1;
        lru_way              = r_victim_q;
        // Return to IDLE so the request re-evaluates as a hit and merges data.
        w_state_nxt          = S_IDLE;
      end
      S_RESP: begin
        mem_resp    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else if (perf_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (w_idle_hit  && (hit_count  != '1)) hit_count  <= hit_count  + 1'b1;
      if (w_idle_miss && (miss_count != '1)) miss_count <= miss_count + 1'b1;
      if (w_wb_exit   && (wb_count   != '1)) wb_count   <= wb_count   + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l2cache_control_nway.sv
// Directed bench for l2cache_control_nway: a 4-way and an 8-way instance.
// Counter checks are compiled in only when L2_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_l2cache_control_nway;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-way instance signals
  logic       a_rd, a_wr, a_presp;
  logic [3:0] a_hit, a_valid, a_dirty;
  logic [1:0] a_plru;
  logic       a_resp, a_pread, a_pwrite, a_asel, a_bsel, a_din, a_lru;
  logic [1:0] a_wsel, a_lway;
  logic [3:0] a_we, a_ldv, a_ldd;

  // 8-way instance signals
  logic       b_rd, b_wr, b_presp;
  logic [7:0] b_hit, b_valid, b_dirty;
  logic [2:0] b_plru;
  logic       b_resp, b_pread, b_pwrite, b_asel, b_bsel, b_din, b_lru;
  logic [2:0] b_wsel, b_lway;
  logic [7:0] b_we, b_ldv, b_ldd;

`ifdef L2_PERF_CNT_EN
  logic        a_pclr, b_pclr;
  logic [31:0] a_hc, a_mc, a_wc, b_hc, b_mc, b_wc;
`endif

  l2cache_control_nway #(.WAYS(4)) u_dut4 (
    .clk(clk), .reset(reset), .mem_read(a_rd), .mem_write(a_wr),
    .hit(a_hit), .valid(a_valid), .dirty(a_dirty), .plru_victim(a_plru),
    .pmem_resp(a_presp),
`ifdef L2_PERF_CNT_EN
    .perf_clr(a_pclr), .hit_count(a_hc), .miss_count(a_mc), .wb_count(a_wc),
`endif
    .mem_resp(a_resp), .pmem_read(a_pread), .pmem_write(a_pwrite),
    .mem_addr_sel(a_asel), .way_sel(a_wsel), .mem_b_sel(a_bsel), .we(a_we),
    .ld_valid(a_ldv), .ld_dirty(a_ldd), .dirty_in(a_din),
    .lru_update(a_lru), .lru_way(a_lway)
  );

  l2cache_control_nway #(.WAYS(8)) u_dut8 (
    .clk(clk), .reset(reset), .mem_read(b_rd), .mem_write(b_wr),
    .hit(b_hit), .valid(b_valid), .dirty(b_dirty), .plru_victim(b_plru),
    .pmem_resp(b_presp),
`ifdef L2_PERF_CNT_EN
    .perf_clr(b_pclr), .hit_count(b_hc), .miss_count(b_mc), .wb_count(b_wc),
`endif
    .mem_resp(b_resp), .pmem_read(b_pread), .pmem_write(b_pwrite),
    .mem_addr_sel(b_asel), .way_sel(b_wsel), .mem_b_sel(b_bsel), .we(b_we),
    .ld_valid(b_ldv), .ld_dirty(b_ldd), .dirty_in(b_din),
    .lru_update(b_lru), .lru_way(b_lway)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_rd = 0; a_wr = 0; a_presp = 0; a_hit = 0; a_valid = 0; a_dirty = 0; a_plru = 0;
    b_rd = 0; b_wr = 0; b_presp = 0; b_hit = 0; b_valid = 0; b_dirty = 0; b_plru = 0;
`ifdef L2_PERF_CNT_EN
    a_pclr = 0; b_pclr = 0;
`endif
    #1;
    check("rst_pmem_read", a_pread, 0);
    check("rst_outputs", {a_resp, a_pwrite, a_asel, a_bsel, a_din, a_lru, a_we, a_ldv, a_ldd}, 0);
    tick();
    reset = 1'b0;
    tick();

    // 1: read hit on way 2
    a_rd = 1; a_hit = 4'b0100; a_valid = 4'b1111;
    #1;
    check("s1_lru_update", a_lru, 1);
    check("s1_lru_way", a_lway, 2);
    check("s1_way_sel", a_wsel, 2);
    check("s1_no_we", a_we, 0);
    check("s1_resp_c0", a_resp, 0);
    tick();
    check("s1_resp", a_resp, 1);
    check("s1_no_pmem", {a_pread, a_pwrite}, 0);
    a_rd = 0; a_hit = 0;
    tick();
    check("s1_resp_drop", a_resp, 0);

    // 2: write miss, way 2 invalid is preferred over a dirty PLRU victim
    a_wr = 1; a_hit = 0; a_valid = 4'b1011; a_dirty = 4'b1111; a_plru = 2'd0;
    tick();
    check("s2_no_wb", a_pwrite, 0);
    check("s2_fill", a_pread, 1);
    check("s2_addr_sel", a_asel, 0);
    tick();
    check("s2_fill_hold", a_pread, 1);
    a_presp = 1;
    tick();
    a_presp = 0;
    check("s2_load_we", a_we, 4'b0100);
    check("s2_load_ldv", a_ldv, 4'b0100);
    check("s2_load_ldd", a_ldd, 4'b0100);
    check("s2_load_din", a_din, 1);
    check("s2_load_bsel", a_bsel, 1);
    check("s2_load_lru", {a_lru, a_lway}, {1'b1, 2'd2});
    check("s2_load_no_pmem", {a_pread, a_pwrite}, 0);
    tick();
    a_hit = 4'b0100; a_valid = 4'b1111;
    #1;
    check("s2_rehit_we", a_we, 4'b0100);
    check("s2_rehit_din", a_din, 1);
    check("s2_no_resp_yet", a_resp, 0);
    tick();
    check("s2_resp", a_resp, 1);
    a_wr = 0; a_hit = 0;
    tick();

    // 3: read miss, dirty PLRU victim way 3 -> write-back then fill
    a_rd = 1; a_hit = 0; a_valid = 4'b1111; a_dirty = 4'b1000; a_plru = 2'd3;
    tick();
    a_plru = 2'd1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) a_presp = 1;
      #1;
      check($sformatf("s3_wb%0d", i), {a_pwrite, a_pread, a_asel, a_wsel}, {1'b1, 1'b0, 1'b1, 2'd3});
      check($sformatf("s3_wb%0d_ldd", i), {a_ldd, a_din}, (i == 4) ? {4'b1000, 1'b0} : 5'd0);
      tick();
    end
    a_presp = 0;
    check("s3_fill", {a_pread, a_pwrite}, 2'b10);
    tick();
    a_presp = 1;
    #1;
    check("s3_fill2", a_pread, 1);
    tick();
    a_presp = 0;
    check("s3_load", {a_we, a_ldv, a_din}, {4'b1000, 4'b1000, 1'b0});
    check("s3_load_lru", a_lway, 3);
    tick();
    a_hit = 4'b1000;
    #1;
    check("s3_rehit", {a_lru, a_lway, a_we}, {1'b1, 2'd3, 4'b0000});
    tick();
    check("s3_resp", a_resp, 1);
    a_rd = 0; a_hit = 0; a_dirty = 0;
    tick();

`ifdef L2_PERF_CNT_EN
    // 6: counters after scenarios 1-3, then clear
    check("s6_hit_count", a_hc, 3);
    check("s6_miss_count", a_mc, 2);
    check("s6_wb_count", a_wc, 1);
    a_pclr = 1;
    tick();
    a_pclr = 0;
    check("s6_clr", {a_hc, a_mc, a_wc}, 0);
`endif

    // pmem_resp in IDLE is ignored
    a_presp = 1;
    tick();
    a_presp = 0;
    check("idle_presp_ignored", {a_pread, a_pwrite, a_resp, a_we}, 0);

    // 4: reset asserted during FILL cycle 3
    a_rd = 1; a_hit = 0; a_valid = 4'b1111; a_dirty = 0;
    tick();
    tick();
    tick();
    check("s4_fill_c3", a_pread, 1);
    #2 reset = 1'b1;
    #1;
    check("s4_async_drop", a_pread, 0);
    check("s4_no_strobe", {a_we, a_ldv, a_resp}, 0);
    a_rd = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    a_rd = 1; a_hit = 4'b0001;
    #1;
    check("s4_idle_hit", {a_lru, a_lway}, {1'b1, 2'd0});
    tick();
    a_rd = 0; a_hit = 0;
    tick();

    // 5: 8-way, all valid and clean, PLRU victim 7 -> straight to fill
    b_rd = 1; b_hit = 0; b_valid = 8'hFF; b_dirty = 8'h00; b_plru = 3'd7;
    tick();
    check("s5_no_wb", {b_pwrite, b_pread}, 2'b01);
    b_presp = 1;
    tick();
    b_presp = 0;
    check("s5_load_we", b_we, 8'h80);
    check("s5_load_ldv", b_ldv, 8'h80);
    check("s5_load_lru", b_lway, 7);
    tick();
    b_hit = 8'h80;
    tick();
    check("s5_resp", b_resp, 1);
    b_rd = 0; b_hit = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
